axis_video_frame_fifo: RTL and testbench
========================================

Name: axis_video_frame_fifo

Overview:
- Sits directly downstream of the MT9V sensor-to-AXIS bridge, in the pclk domain.
- The bridge cannot honour backpressure: its tvalid follows the sensor pixel timing and it ignores tready. This block absorbs downstream stalls in a FIFO.
- On overflow it discards the remainder of the current frame and resynchronises on the next start-of-frame (tuser), so downstream IP (filter, VDMA) never sees a mid-frame pixel gap.
- The master side is a standard AXI4-Stream video interface.

Parameters:
- DATA_W, 8, pixel width of tdata
- ADDR_W, 10, FIFO address width; depth = 2**ADDR_W entries, each {tuser, tlast, tdata}

Ports:
- pclk  in  1  pixel clock; the single clock of the block
- resetn  in  1  asynchronous active-low reset
- s_axis_video_tdata  in  DATA_W  pixel from the bridge
- s_axis_video_tvalid  in  1  pixel valid
- s_axis_video_tuser  in  1  start of frame, qualified by tvalid
- s_axis_video_tlast  in  1  end of line, qualified by tvalid; may stay high while tvalid=0
- s_axis_video_tready  out  1  constant 1 out of reset; informational only
- m_axis_video_tdata  out  DATA_W  pixel out
- m_axis_video_tvalid  out  1  output valid
- m_axis_video_tuser  out  1  start of frame
- m_axis_video_tlast  out  1  end of line
- m_axis_video_tready  in  1  downstream ready
- fifo_level  out  ADDR_W+1  current occupancy
- overflow  out  1  sticky; set on the first dropped beat, cleared only by reset

Behaviour:
- Reset: clock and reset are as fixed above (pclk; resetn asynchronous, active-low).
  - Pointers, level and FSM are cleared immediately.
  - All m_axis outputs, s_axis_video_tready, overflow and fifo_level read 0.
  - FSM starts in WAIT_SOF.
- Input beat: s_tvalid=1 at a rising pclk edge. The s_tlast and s_tuser levels are ignored when s_tvalid=0.
- Write-side FSM:
  - WAIT_SOF: discard beats until a beat has tuser=1.
    - If that beat arrives with the FIFO not full: write it, go to PASS.
    - If the FIFO is full: drop the beat, set overflow, stay in WAIT_SOF.
  - PASS: write every beat while not full.
    - A beat arriving when full is dropped: set overflow, go to DROP.
  - DROP: discard beats until one has tuser=1, then handle it exactly as in WAIT_SOF.
  - A tuser beat seen in PASS is written normally; there is no special handling.
- Full/empty and simultaneous access:
  - full = (level == 2**ADDR_W). Full is evaluated on registered level only, with no read lookahead: a write is refused when full even if a read occurs in the same cycle.
  - A simultaneous read and write leaves level unchanged.
  - Pointers are ADDR_W+1 bits wide and wrap naturally.
- Read side (first-word fall-through):
  - m_tvalid = (level != 0). m_tdata, m_tuser and m_tlast present the head entry.
  - The entry is popped on m_tvalid & m_tready.
  - m_tvalid never drops without a handshake.
  - The m_axis outputs are registered: head-entry changes after a pop are visible the cycle after the pop edge.
- Latency: a beat written at edge k into an empty FIFO gives m_tvalid=1 after edge k+1. Steady-state throughput is 1 beat/clk.
- Frames are never reordered or merged. A dropped frame is truncated; its tail is replaced by the next frame's tuser beat.
- s_tready = 1 from the first edge after reset release. Memory is inferred as simple dual-port RAM with a registered output plus a 1-entry bypass register so fall-through holds.

Optional Feature:
- Macro: AXIS_FRAME_FIFO_DROP_CNT_EN.
- Defined: adds output port frames_dropped [15:0].
  - Increments by 1 on each PASS->DROP transition.
  - Increments by 1 on each tuser beat dropped in WAIT_SOF/DROP because the FIFO was full.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan (ADDR_W=4, depth 16):
- Reset, then a 4x2 frame (8 beats, tuser on beat 0, tlast on beats 3 and 7), m_tready=1 -> output shows the identical 8 beats with matching tuser/tlast; first m_tvalid one cycle after the first write; fifo_level ≤1; overflow=0.
- Stream starts mid-frame (3 beats, no tuser), then a full 8-beat frame -> the 3 beats are discarded; exactly 8 beats are output, the first with tuser=1.
- m_tready=0, send a 20-beat frame -> fifo_level=16, beats 17-20 dropped, overflow=1. Release m_tready; a following 8-beat frame -> 16 beats then 8 beats output, the second run starting with tuser=1.
- 8-beat frames at a 1/2 input duty with m_tready toggling 1/0 -> no overflow; all beats are output in order.
- resetn pulled low mid-frame with level=5 -> m_tvalid=0 and fifo_level=0 without waiting for a clock edge; after release the post-SOF beats are ignored until the next tuser.
- With AXIS_FRAME_FIFO_DROP_CNT_EN, repeat the overflow scenario over 3 frames -> frames_dropped=3.

Source files
------------

// File: rtl/axis_video_frame_fifo.sv
// Purpose : frame-aware AXI4-Stream video FIFO behind a sensor bridge that ignores tready;
//           on overflow it drops the rest of the frame and resyncs on the next tuser beat.
// Latency : beat sampled at edge k -> m_axis_video_tvalid after edge k+1; 1 beat/clk sustained.
// Backpressure: none upstream (s_axis_video_tready is informational); downstream stalls are
//           absorbed by 2**ADDR_W entries, beyond which beats are discarded frame-wise.
// Ports   : pclk/resetn (async active-low); s_axis_video_* from the bridge; m_axis_video_*
//           first-word fall-through output; fifo_level occupancy; overflow sticky drop flag.
// Option  : AXIS_FRAME_FIFO_DROP_CNT_EN adds frames_dropped[15:0], a saturating count of
//           frames lost to overflow.
module axis_video_frame_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              pclk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_axis_video_tdata,
    input  logic              s_axis_video_tvalid,
    input  logic              s_axis_video_tuser,
    input  logic              s_axis_video_tlast,
    output logic              s_axis_video_tready,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    input  logic              m_axis_video_tready,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow
`ifdef AXIS_FRAME_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]       frames_dropped
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int ENT_W = DATA_W + 2;   // {tuser, tlast, tdata}

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PASS     = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Input capture stage: the keep/drop decision is made one edge later against the
    // registered level, so the full check is exact for the beat actually being written.
    logic              in_vld_q;
    logic              in_user_q;
    logic              in_last_q;
    logic [DATA_W-1:0] in_data_q;

    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              wr_en;
    logic              drop_full;
    logic              pop;
    logic              ovf_q, ovf_d;
    logic              s_rdy_q;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  wr_ent;
    logic [ENT_W-1:0]  head_q, head_d;

    assign level  = wptr_q - rptr_q;
    assign full   = (level == DEPTH[ADDR_W:0]);
    assign pop    = (level != '0) && m_axis_video_tready;
    assign wr_ent = {in_user_q, in_last_q, in_data_q};

    // Write-side frame FSM
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        drop_full = 1'b0;
        case (state_q)
            PASS: begin
                if (in_vld_q) begin
                    if (!full) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_full = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            default: begin
                // WAIT_SOF and DROP behave identically: only a tuser beat can (re)open a frame.
                if (in_vld_q && in_user_q) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        state_d = PASS;
                    end else begin
                        drop_full = 1'b1;
                        state_d   = WAIT_SOF;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wptr_d = wptr_q + (ADDR_W+1)'(wr_en);
        rptr_d = rptr_q + (ADDR_W+1)'(pop);
        ovf_d  = ovf_q | drop_full;
        // Registered-read RAM: fetch the entry that will be head after this edge. If that
        // entry is being written on this very edge the RAM cannot return it yet, so bypass.
        if (wr_en && (wptr_q[ADDR_W-1:0] == rptr_d[ADDR_W-1:0])) begin
            head_d = wr_ent;
        end else begin
            head_d = mem[rptr_d[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wptr_q[ADDR_W-1:0]] <= wr_ent;
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= WAIT_SOF;
            in_vld_q  <= 1'b0;
            in_user_q <= 1'b0;
            in_last_q <= 1'b0;
            in_data_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ovf_q     <= 1'b0;
            s_rdy_q   <= 1'b0;
            head_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_vld_q  <= s_axis_video_tvalid;
            in_user_q <= s_axis_video_tuser;
            in_last_q <= s_axis_video_tlast;
            in_data_q <= s_axis_video_tdata;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ovf_q     <= ovf_d;
            s_rdy_q   <= 1'b1;
            head_q    <= head_d;
        end
    end

    assign s_axis_video_tready = s_rdy_q;
    assign m_axis_video_tvalid = (level != '0);
    assign m_axis_video_tuser  = head_q[ENT_W-1];
    assign m_axis_video_tlast  = head_q[ENT_W-2];
    assign m_axis_video_tdata  = head_q[DATA_W-1:0];
    assign fifo_level          = level;
    assign overflow            = ovf_q;

`ifdef AXIS_FRAME_FIFO_DROP_CNT_EN
    // Every full-drop is either the PASS->DROP truncation or a refused tuser beat,
    // so each one marks exactly one lost frame.
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_full && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign frames_dropped = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_video_frame_fifo.sv
// Purpose : directed self-checking bench for axis_video_frame_fifo (DATA_W=8, ADDR_W=4).
// Latency : n/a (bench).
// Backpressure: m_axis_video_tready driven per scenario.
module tb_axis_video_frame_fifo;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          pclk = 1'b0;
    logic          resetn;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tuser;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tuser;
    logic          m_tlast;
    logic          m_tready;
    logic [AW:0]   fifo_level;
    logic          overflow;
`ifdef AXIS_FRAME_FIFO_DROP_CNT_EN
    logic [15:0]   frames_dropped;
`endif

    int checks = 0;
    int passed = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always #5 pclk = ~pclk;

    axis_video_frame_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .pclk                (pclk),
        .resetn              (resetn),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tready (s_tready),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tready (m_tready),
        .fifo_level          (fifo_level),
        .overflow            (overflow)
`ifdef AXIS_FRAME_FIFO_DROP_CNT_EN
        ,
        .frames_dropped      (frames_dropped)
`endif
    );

    // Output monitor: a beat valid and ready at the falling edge is popped on the next rising edge.
    always @(negedge pclk) begin
        if (resetn && m_tvalid && m_tready) begin
            got_q.push_back({m_tuser, m_tlast, m_tdata});
        end
    end

    task automatic cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        cycle();
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        resetn   = 1'b0;
        repeat (2) cycle();
        resetn = 1'b1;
        cycle();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        #3;
        checks++;
        if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== 11'd0)
            $display("FAIL reset_m_axis: got %h want 000", {m_tvalid, m_tuser, m_tlast, m_tdata});
        else passed++;
        checks++;
        if (fifo_level !== 5'd0) $display("FAIL reset_level: got %0d want 0", fifo_level);
        else passed++;
        checks++;
        if ({overflow, s_tready} !== 2'b00)
            $display("FAIL reset_ovf_rdy: got %b want 00", {overflow, s_tready});
        else passed++;
        repeat (2) cycle();
        resetn = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b0) $display("FAIL rdy_before_edge: got %b want 0", s_tready);
        else passed++;
        cycle();
        checks++;
        if (s_tready !== 1'b1) $display("FAIL rdy_after_edge: got %b want 1", s_tready);
        else passed++;
    endtask

    task automatic test_basic_frame();
        logic [4:0] maxlvl;
        logic       u, l;
        apply_reset();
        m_tready = 1'b1;
        maxlvl   = '0;
        for (int i = 0; i < 8; i++) begin
            u = (i == 0);
            l = (i == 3) || (i == 7);
            exp_q.push_back({u, l, 8'h10 + 8'(i)});
            send(8'h10 + 8'(i), u, l);
            if (fifo_level > maxlvl) maxlvl = fifo_level;
            if (i == 0) begin
                checks++;
                if (m_tvalid !== 1'b0) $display("FAIL latency_early: got tvalid %b want 0", m_tvalid);
                else passed++;
            end
            if (i == 1) begin
                checks++;
                if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 1'b1, 8'h10})
                    $display("FAIL latency_first: got %h want 310", {m_tvalid, m_tuser, m_tdata});
                else passed++;
            end
        end
        idle(6);
        checks++;
        if (maxlvl > 5'd1) $display("FAIL basic_maxlevel: got %0d want <=1", maxlvl);
        else passed++;
        checks++;
        if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", overflow);
        else passed++;
        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_midframe_start();
        apply_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0, i == 2);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({i == 0, (i == 3) || (i == 7), 8'h20 + 8'(i)});
            send(8'h20 + 8'(i), i == 0, (i == 3) || (i == 7));
        end
        idle(6);
        checks++;
        if (got_q.size() != 8) $display("FAIL midframe_count: got %0d want 8", got_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL midframe_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back({i == 0, (i % 4) == 3, 8'h40 + 8'(i)});
            send(8'h40 + 8'(i), i == 0, (i % 4) == 3);
        end
        idle(3);
        checks++;
        if (fifo_level !== 5'd16) $display("FAIL ovf_level: got %0d want 16", fifo_level);
        else passed++;
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);
        else passed++;
        checks++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 1'b1, 8'h40})
            $display("FAIL ovf_head: got %h want 340", {m_tvalid, m_tuser, m_tdata});
        else passed++;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({i == 0, (i == 3) || (i == 7), 8'h80 + 8'(i)});
            send(8'h80 + 8'(i), i == 0, (i == 3) || (i == 7));
        end
        idle(30);
        checks++;
        if (fifo_level !== 5'd0) $display("FAIL ovf_drained: got %0d want 0", fifo_level);
        else passed++;
        checks++;
        if (got_q.size() != 24) $display("FAIL ovf_count: got %0d want 24", got_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_half_duty();
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({i == 0, (i == 3) || (i == 7), 8'hC0 + 8'(f * 8 + i)});
                m_tready = 1'b1;
                send(8'hC0 + 8'(f * 8 + i), i == 0, (i == 3) || (i == 7));
                m_tready = 1'b0;
                idle(1);
            end
        end
        m_tready = 1'b1;
        idle(6);
        checks++;
        if (overflow !== 1'b0) $display("FAIL duty_overflow: got %b want 0", overflow);
        else passed++;
        checks++;
        if (got_q.size() != 16) $display("FAIL duty_count: got %0d want 16", got_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL duty_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i), i == 0, 1'b0);
        idle(2);
        checks++;
        if (fifo_level !== 5'd5) $display("FAIL rstmid_pre_level: got %0d want 5", fifo_level);
        else passed++;
        resetn = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) $display("FAIL rstmid_tvalid: got %b want 0", m_tvalid);
        else passed++;
        checks++;
        if (fifo_level !== 5'd0) $display("FAIL rstmid_level: got %0d want 0", fifo_level);
        else passed++;
        #2;
        resetn = 1'b1;
        cycle();
        got_q.delete();
        m_tready = 1'b1;
        for (int i = 5; i < 8; i++) send(8'hE0 + 8'(i), 1'b0, i == 7);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({i == 0, (i == 3) || (i == 7), 8'hF0 + 8'(i)});
            send(8'hF0 + 8'(i), i == 0, (i == 3) || (i == 7));
        end
        idle(6);
        checks++;
        if (got_q.size() != 8) $display("FAIL rstmid_count: got %0d want 8", got_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rstmid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

`ifdef AXIS_FRAME_FIFO_DROP_CNT_EN
    task automatic test_drop_cnt();
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            m_tready = 1'b0;
            for (int i = 0; i < 20; i++) send(8'h30 + 8'(i), i == 0, (i % 4) == 3);
            idle(2);
            m_tready = 1'b1;
            idle(22);
        end
        checks++;
        if (frames_dropped !== 16'd3) $display("FAIL drop_cnt: got %0d want 3", frames_dropped);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_midframe_start();
        test_overflow();
        test_half_duty();
        test_reset_midframe();
`ifdef AXIS_FRAME_FIFO_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
